bee_motion: RTL and testbench

Per-frame position controller for the Bee sprite, directly upstream of the sprite renderer. It takes the VGA timing coordinates and two player buttons. It updates the sprite's top-left position once per frame, at the start of vertical blanking, so the position is stable for the whole visible frame. With no input for a set number of frames, it enters an attract mode that bounces the bee between the screen edges.

---
 rtl/bee_motion_pkg.sv | 15 +
 rtl/bee_motion_if.sv | 23 ++
 rtl/bee_motion_btn_sync.sv | 22 ++
 rtl/bee_motion.sv | 131 +++++++++++++
 tb/tb_bee_motion.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bee_motion_pkg.sv
// Shared screen geometry and state encoding for the Bee sprite position controller.
package bee_motion_pkg;
  localparam int CORDW = 10;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int BEE_W = 34;
  localparam int BEE_H = 20;
  localparam int MAX_X = H_RES - BEE_W;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO_R = 2'd1,
    AUTO_L = 2'd2
  } bee_state_e;
endpackage

// File: rtl/bee_motion_if.sv
// Timing coordinates and buttons in, sprite position and status out.
interface bee_motion_if;
  import bee_motion_pkg::*;

  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             btn_left;
  logic             btn_right;
  logic [CORDW-1:0] BeeX;
  logic [CORDW-1:0] BeeY;
  logic             frame_tick;
  logic             auto_mode;

  modport master (
    output sx, sy, btn_left, btn_right,
    input  BeeX, BeeY, frame_tick, auto_mode
  );

  modport slave (
    input  sx, sy, btn_left, btn_right,
    output BeeX, BeeY, frame_tick, auto_mode
  );
endinterface

// File: rtl/bee_motion_btn_sync.sv
// Two-flop synchronizer bringing a raw button level into the pixel clock domain.
module bee_motion_btn_sync (
  input  logic clk_pix,
  input  logic rst_pix,
  input  logic async_i,
  output logic sync_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;
endmodule

// File: rtl/bee_motion.sv
// Per-frame Bee sprite X controller: manual steering from two buttons, with an
// attract mode that bounces the sprite between screen edges after an idle period.
module bee_motion
  import bee_motion_pkg::*;
#(
  parameter logic [CORDW-1:0] BEE_Y       = 10'd400,
  parameter logic [CORDW-1:0] START_X     = 10'd303,
  parameter int               STEP        = 2,
  parameter int               IDLE_FRAMES = 600
) (
  input  logic      clk_pix,
  input  logic      rst_pix,
  bee_motion_if.slave bus
);
  localparam int               IDLE_W    = $clog2(IDLE_FRAMES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FRAMES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [CORDW:0]   STEP_W    = (CORDW + 1)'(STEP);
  localparam logic [CORDW:0]   MAX_W     = (CORDW + 1)'(MAX_X);
  localparam logic [CORDW-1:0] MAX_XC    = CORDW'(MAX_X);
  localparam logic [CORDW-1:0] V_BLANK   = CORDW'(V_RES);

  logic [1:0] btn_raw;
  logic [1:0] btn_s;

  assign btn_raw = {bus.btn_right, bus.btn_left};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    bee_motion_btn_sync u_sync (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .async_i (btn_raw[gi]),
      .sync_o  (btn_s[gi])
    );
  end

  bee_state_e       state_q, state_d;
  logic [CORDW-1:0] x_q, x_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic             tick_q;
  logic             auto_q;

  logic             any_btn, mv_l, mv_r;
  logic [CORDW:0]   sum_w, diff_w;
  logic [CORDW-1:0] left_x, right_x, moved_x;
  logic             at_right, at_left;

  assign any_btn = |btn_s;
  assign mv_l    = btn_s[0] & ~btn_s[1];
  assign mv_r    = btn_s[1] & ~btn_s[0];

  // One extra bit lets the borrow/carry drive saturation instead of wrapping.
  assign sum_w    = {1'b0, x_q} + STEP_W;
  assign diff_w   = {1'b0, x_q} - STEP_W;
  assign at_right = (sum_w >= MAX_W);
  assign at_left  = diff_w[CORDW] || (diff_w == '0);
  assign right_x  = at_right ? MAX_XC : sum_w[CORDW-1:0];
  assign left_x   = diff_w[CORDW] ? '0 : diff_w[CORDW-1:0];
  assign moved_x  = mv_l ? left_x : (mv_r ? right_x : x_q);

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      tick_q  <= 1'b0;
      state_q <= MANUAL;
      x_q     <= START_X;
      idle_q  <= '0;
      auto_q  <= 1'b0;
    end else begin
      tick_q  <= (bus.sx == '0) && (bus.sy == V_BLANK);
      state_q <= state_d;
      x_q     <= x_d;
      idle_q  <= idle_d;
      auto_q  <= (state_d != MANUAL);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idle_d  = idle_q;
    if (tick_q) begin
      case (state_q)
        MANUAL: begin
          if (any_btn) begin
            idle_d = '0;
            x_d    = moved_x;
          end else if (idle_q == IDLE_LAST) begin
            // Entering attract leaves X untouched on this tick.
            idle_d  = '0;
            state_d = AUTO_R;
          end else begin
            idle_d = idle_q + IDLE_ONE;
          end
        end
        AUTO_R: begin
          if (any_btn) begin
            idle_d  = '0;
            state_d = MANUAL;
            x_d     = moved_x;
          end else if (at_right) begin
            x_d     = MAX_XC;
            state_d = AUTO_L;
          end else begin
            x_d = sum_w[CORDW-1:0];
          end
        end
        AUTO_L: begin
          if (any_btn) begin
            idle_d  = '0;
            state_d = MANUAL;
            x_d     = moved_x;
          end else if (at_left) begin
            x_d     = '0;
            state_d = AUTO_R;
          end else begin
            x_d = diff_w[CORDW-1:0];
          end
        end
        default: begin
          state_d = MANUAL;
          idle_d  = '0;
        end
      endcase
    end
  end

  assign bus.BeeX       = x_q;
  assign bus.BeeY       = BEE_Y;
  assign bus.frame_tick = tick_q;
  assign bus.auto_mode  = auto_q;
endmodule

// File: tb/tb_bee_motion.sv
// Scoreboard bench for bee_motion: stimulus queues the expected post-tick state,
// a monitor compares it one cycle after every frame_tick.
module tb_bee_motion;
  import bee_motion_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bee_motion_if bus ();

  bee_motion #(
    .BEE_Y       (10'd400),
    .START_X     (10'd303),
    .STEP        (2),
    .IDLE_FRAMES (4)
  ) dut (
    .clk_pix (clk),
    .rst_pix (rst),
    .bus     (bus)
  );

  typedef struct {
    int x;
    int au;
    int ph;
    int fr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every tick, the new position is visible one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.frame_tick) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("tick p%0d f%0d BeeX=%0d auto=%0d exp=%0d/%0d",
                   e.ph, e.fr, bus.BeeX, bus.auto_mode, e.x, e.au);
          check($sformatf("beex_p%0d_f%0d", e.ph, e.fr), int'(bus.BeeX), e.x);
          check($sformatf("auto_p%0d_f%0d", e.ph, e.fr), int'(bus.auto_mode), e.au);
        end
      end
    end
  end

  task automatic frame(input logic l, input logic r, input int ex, input int ea,
                       input int ph, input int fr);
    @(negedge clk);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.sx = 10'd5;
    bus.sy = 10'd10;
    repeat (5) @(negedge clk);
    sb.push_back('{ex, ea, ph, fr});
    bus.sx = 10'd0;
    bus.sy = 10'd480;
    @(negedge clk);
    bus.sx = 10'd1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.sx = 10'd5;
    bus.sy = 10'd10;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int hit;
    int idx;

    rst = 1'b1;
    bus.sx = '0;
    bus.sy = '0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_beex", int'(bus.BeeX), 303);
    check("rst_beey", int'(bus.BeeY), 400);
    check("rst_tick", int'(bus.frame_tick), 0);
    check("rst_auto", int'(bus.auto_mode), 0);
    rst = 1'b0;

    // Coordinates parked at the origin never match.
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_tick) n++;
    end
    check("no_tick_at_origin", n, 0);

    // Mini raster around the blanking start: one pulse, the cycle after (0,480).
    sb.push_back('{303, 0, 0, 0});
    n = 0; hit = -1; idx = 0;
    for (int y = 478; y <= 481; y++) begin
      for (int xx = 0; xx < 4; xx++) begin
        @(negedge clk);
        if (bus.frame_tick) begin
          n++;
          hit = idx;
        end
        bus.sx = 10'(xx);
        bus.sy = 10'(y);
        idx++;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.frame_tick) n++;
    end
    check("tick_count", n, 1);
    check("tick_cycle", hit, 9);

    // Idle from reset: attract after tick 4, first bounce step on tick 5.
    do_reset();
    for (int k = 1; k <= 5; k++)
      frame(1'b0, 1'b0, (k <= 4) ? 303 : 305, (k >= 4) ? 1 : 0, 1, k);

    // Left pulse during attract returns to manual and steps left.
    for (int k = 1; k <= 3; k++)
      frame(1'b1, 1'b0, 305 - 2 * k, 0, 2, k);

    // Both buttons: no move, idle count restarts.
    for (int k = 1; k <= 3; k++) frame(1'b0, 1'b0, 299, 0, 3, k);
    frame(1'b1, 1'b1, 299, 0, 3, 4);
    for (int k = 5; k <= 7; k++) frame(1'b0, 1'b0, 299, 0, 3, k);
    frame(1'b0, 1'b0, 299, 1, 3, 8);

    // Reset asserted right after a tick rises, while in attract mode.
    @(negedge clk);
    bus.sx = 10'd0;
    bus.sy = 10'd480;
    @(posedge clk);
    #2;
    check("tick_before_rst", int'(bus.frame_tick), 1);
    rst = 1'b1;
    #1;
    check("midrst_beex", int'(bus.BeeX), 303);
    check("midrst_tick", int'(bus.frame_tick), 0);
    check("midrst_auto", int'(bus.auto_mode), 0);
    bus.sx = 10'd5;
    bus.sy = 10'd10;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Right held: saturates at 606 from frame 152.
    for (int k = 1; k <= 160; k++)
      frame(1'b0, 1'b1, (303 + 2 * k > 606) ? 606 : 303 + 2 * k, 0, 5, k);

    // Step to 604, go idle into attract, bounce off the right edge.
    frame(1'b1, 1'b0, 604, 0, 6, 1);
    for (int k = 2; k <= 4; k++) frame(1'b0, 1'b0, 604, 0, 6, k);
    frame(1'b0, 1'b0, 604, 1, 6, 5);
    frame(1'b0, 1'b0, 606, 1, 6, 6);
    frame(1'b0, 1'b0, 604, 1, 6, 7);
    frame(1'b0, 1'b0, 602, 1, 6, 8);

    // Left held from reset: reaches 1, then clamps at 0.
    do_reset();
    for (int k = 1; k <= 160; k++)
      frame(1'b1, 1'b0, (303 - 2 * k < 0) ? 0 : 303 - 2 * k, 0, 7, k);
    frame(1'b0, 1'b0, 0, 0, 7, 161);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
